// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, one valid/ready word per 8N1-style frame with optional parity
// Ports: clk system clock; rst_n async active-low reset; tx_vld/tx_data upstream word (sampled on accept);
//        tx_rdy high only when idle; uart_tx serial line (idles high); tx_busy high while a frame is on the line;
//        tx_done one-cycle pulse at frame completion.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit selected by PARITY (0 none, 1 odd, 2 even).
module uart_tx_frame #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_vld,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_rdy,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW = DIV > 1 ? $clog2(DIV) : 1;
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || DIV < 2) begin : g_bad_param
    $error("uart_tx_frame: unsupported DATA_BITS, STOP_BITS or clock/baud ratio");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;
  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   rdy_q, rdy_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tick;
  logic                   par_q;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = PARITY != 0;
  logic par_d;
  // parity is taken from the word as latched, so later tx_data changes cannot affect it
  always_comb par_d = (tx_vld && rdy_q) ? (PARITY == 1 ? ~^tx_data : ^tx_data) : par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par_q <= 1'b0;
    else par_q <= par_d;
`else
  localparam bit PAR_ON = 1'b0 & (PARITY != 0);
  assign par_q = 1'b0;
`endif
  assign tick = baud_q == BW'(DIV - 1);
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == S_IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (tx_vld && rdy_q) begin
        state_d = S_START;
        shreg_d = tx_data;
        bit_d   = '0;
        tx_d    = 1'b0;
        rdy_d   = 1'b0;
        busy_d  = 1'b1;
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        tx_d    = shreg_q[0];
      end
      S_DATA: if (tick) begin
        if (bit_q == 4'(DATA_BITS - 1)) begin
          state_d = PAR_ON ? S_PAR : S_STOP;
          tx_d    = PAR_ON ? par_q : 1'b1;
          bit_d   = '0;
        end else begin
          // bit k+1 sits at index 1 of the word shifted k times
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
          bit_d   = bit_q + 1'b1;
        end
      end
      S_PAR: if (tick) begin
        state_d = S_STOP;
        tx_d    = 1'b1;
      end
      S_STOP: if (tick) begin
        if (bit_q == 4'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          bit_d   = '0;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign uart_tx = tx_q;
  assign tx_rdy  = rdy_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized and directed checks of uart_tx_frame against a frame-timeline model
module tb_uart_tx_frame;
  localparam int N = 4;
  localparam int DB [N] = '{8, 7, 7, 8};
  localparam int SB [N] = '{1, 2, 2, 1};
  localparam int PM [N] = '{0, 2, 1, 2};
  localparam int CK [N] = '{1_000_000, 1_000_000, 1_000_000, 1_000_000};
  localparam int BD [N] = '{100_000, 100_000, 100_000, 300_000};
`ifdef UART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] tx_vld = '0;
  logic [N-1:0] tx_rdy, uart_tx, tx_busy, tx_done;
  logic [8:0] tx_data [N] = '{default: '0};
  int checks = 0, errors = 0, cyc_n = 0, rk = 0;
  bit act [N];
  bit dm [N];
  int t [N];
  logic [8:0] w [N];
  logic rec_tx [N][256];
  logic rec_rdy [N][256];
  logic rec_done [N][256];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_frame #(.CLK_HZ(CK[g]), .BAUD(BD[g]), .DATA_BITS(DB[g]), .STOP_BITS(SB[g]), .PARITY(PM[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_vld(tx_vld[g]), .tx_data(tx_data[g][DB[g]-1:0]),
      .tx_rdy(tx_rdy[g]), .uart_tx(uart_tx[g]), .tx_busy(tx_busy[g]), .tx_done(tx_done[g]));
  end
  function automatic int dv(int i);
    return (CK[i] + BD[i] / 2) / BD[i];
  endfunction
  function automatic int pon(int i);
    return (PE == 1 && PM[i] != 0) ? 1 : 0;
  endfunction
  function automatic int fb(int i);
    return 1 + DB[i] + pon(i) + SB[i];
  endfunction
  function automatic logic bitv(int i, int j);
    if (j == 0) return 1'b0;
    if (j <= DB[i]) return w[i][j-1];
    if (pon(i) == 1 && j == DB[i] + 1) return PM[i] == 1 ? ~^w[i] : ^w[i];
    return 1'b1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      dm[i] = 1'b0;
      t[i] = 0;
    end
  endtask
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      dm[i] = 1'b0;
      if (!rst_n) act[i] = 1'b0;
      else if (act[i]) begin
        t[i]++;
        if (t[i] == fb(i) * dv(i)) begin
          act[i] = 1'b0;
          dm[i] = 1'b1;
        end
      end else if (tx_vld[i]) begin
        act[i] = 1'b1;
        t[i] = 0;
        w[i] = tx_data[i] & 9'((1 << DB[i]) - 1);
      end
    end
  endtask
  task automatic chk(string nm, int i, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %b, want %b", nm, i, cyc_n, a, e);
    end
  endtask
  task automatic lit(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    cyc_n++;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("uart_tx", i, uart_tx[i], act[i] ? bitv(i, t[i] / dv(i)) : 1'b1);
      chk("tx_rdy", i, tx_rdy[i], !act[i]);
      chk("tx_busy", i, tx_busy[i], act[i]);
      chk("tx_done", i, tx_done[i], dm[i]);
      if (rk < 256) begin
        rec_tx[i][rk] = uart_tx[i];
        rec_rdy[i][rk] = tx_rdy[i];
        rec_done[i][rk] = tx_done[i];
      end
    end
    rk++;
  endtask
  function automatic int first_done(int i);
    for (int k = 0; k < rk && k < 256; k++) if (rec_done[i][k] === 1'b1) return k;
    return -1;
  endfunction
  function automatic int count_done(int i);
    int n = 0;
    for (int k = 0; k < rk && k < 256; k++) if (rec_done[i][k] === 1'b1) n++;
    return n;
  endfunction
  function automatic int next_fall(int i, int from);
    for (int k = from; k < rk && k < 256; k++) if (rec_tx[i][k-1] === 1'b1 && rec_tx[i][k] === 1'b0) return k;
    return -1;
  endfunction
  initial begin
    logic [9:0] pat;
    int n;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    // 8N1 0xA5
    tx_vld[0] = 1'b1;
    tx_data[0] = 9'h0A5;
    rk = 0;
    cyc();
    tx_vld[0] = 1'b0;
    repeat (110) cyc();
    pat = 10'b1101001010;
    for (int j = 0; j < 10; j++) lit("a5_bit", int'(rec_tx[0][j*10+5]), int'(pat[j]));
    lit("a5_done_at", first_done(0), 100);
    lit("a5_done_count", count_done(0), 1);
    lit("a5_rdy_99", int'(rec_rdy[0][99]), 0);
    lit("a5_rdy_100", int'(rec_rdy[0][100]), 1);
    // back-to-back 0x00 then 0xFF with tx_vld held
    tx_vld[0] = 1'b1;
    tx_data[0] = 9'h000;
    rk = 0;
    cyc();
    tx_data[0] = 9'h0FF;
    for (int k = 1; k < 230; k++) begin
      if (k == 150) tx_vld[0] = 1'b0;
      cyc();
    end
    lit("b2b_start_gap", next_fall(0, 1), 101);
    lit("b2b_done_count", count_done(0), 2);
    lit("b2b_gap_idle", int'(rec_tx[0][100]), 1);
    for (int j = 1; j <= 8; j++) lit("b2b_word2_bit", int'(rec_tx[0][101+j*10+5]), 1);
    // 0x41 on the 7-bit/2-stop (even, odd) and DIV=3 instances
    for (int i = 1; i < N; i++) begin
      tx_vld[i] = 1'b1;
      tx_data[i] = 9'h041;
    end
    rk = 0;
    cyc();
    tx_vld = '0;
    repeat (125) cyc();
    lit("even_frame_len", first_done(1), 100 + 10 * PE);
    lit("odd_frame_len", first_done(2), 100 + 10 * PE);
    lit("even_par_bit", int'(rec_tx[1][85]), PE == 1 ? 0 : 1);
    lit("odd_par_bit", int'(rec_tx[2][85]), 1);
    lit("even_stop1", int'(rec_tx[1][(8+PE)*10+5]), 1);
    lit("even_stop2", int'(rec_tx[1][(9+PE)*10+5]), 1);
    lit("div3_frame_len", first_done(3), 3 * (10 + PE));
    lit("div3_bit0", int'(rec_tx[3][4]), 1);
    lit("div3_bit1", int'(rec_tx[3][7]), 0);
    // reset 35 cycles into a frame, then 0x3C
    tx_vld[0] = 1'b1;
    tx_data[0] = 9'h05A;
    rk = 0;
    cyc();
    tx_vld[0] = 1'b0;
    repeat (35) cyc();
    lit("pre_rst_line", int'(uart_tx[0]), 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    lit("rst_line", int'(uart_tx[0]), 1);
    lit("rst_rdy", int'(tx_rdy[0]), 1);
    lit("rst_busy", int'(tx_busy[0]), 0);
    repeat (3) cyc();
    lit("rst_no_done", count_done(0), 0);
    rst_n = 1'b1;
    cyc();
    tx_vld[0] = 1'b1;
    tx_data[0] = 9'h03C;
    rk = 0;
    cyc();
    tx_vld[0] = 1'b0;
    repeat (110) cyc();
    pat = 10'b1001111000;
    for (int j = 0; j < 10; j++) lit("x3c_bit", int'(rec_tx[0][j*10+5]), int'(pat[j]));
    lit("x3c_done_at", first_done(0), 100);
    // tx_vld toggling and tx_data changing mid-frame
    tx_vld[0] = 1'b1;
    tx_data[0] = 9'h0C3;
    rk = 0;
    cyc();
    for (int k = 1; k < 110; k++) begin
      tx_vld[0] = (k < 90) ? 1'(k % 2) : 1'b0;
      tx_data[0] = 9'h0FF;
      cyc();
    end
    n = 0;
    for (int k = 0; k < 100; k++) if (rec_rdy[0][k] === 1'b1) n++;
    lit("busy_rdy_low", n, 0);
    lit("busy_done_at", first_done(0), 100);
    lit("busy_done_count", count_done(0), 1);
    pat = 10'b1110000110;
    for (int j = 0; j < 10; j++) lit("xc3_bit", int'(rec_tx[0][j*10+5]), int'(pat[j]));
    // random traffic with occasional mid-cycle resets
    repeat (4000) begin
      for (int i = 0; i < N; i++) begin
        tx_vld[i] = $urandom_range(0, 7) == 0;
        tx_data[i] = 9'($urandom);
      end
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end
    tx_vld = '0;
    repeat (300) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the sensor-data output path. It serialises one parallel word per valid/ready handshake into an asynchronous frame: one start bit, 5–9 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. Baud rate comes from clock-frequency and baud parameters. It drives the board TX pin directly and signals frame completion to the upstream packetiser.

## Interface

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s; DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles per bit, DIV ≥ 2
- DATA_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even; only honoured when UART_TX_PARITY_EN is defined

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tx_vld  in  1  upstream word valid
- tx_data  in  DATA_BITS  word to send, sampled only on the accept cycle
- tx_rdy  out  1  registered; high only in IDLE
- uart_tx  out  1  serial line, idles high
- tx_busy  out  1  high from the accept edge until the frame completes
- tx_done  out  1  single-cycle pulse at frame completion

## Operation

- Reset values: uart_tx=1, tx_rdy=1, tx_busy=0, tx_done=0. Bit counter, baud counter and shift register are cleared.
- Accept: a word is accepted on any rising edge where tx_vld && tx_rdy.
  - At that edge: tx_data is latched, tx_rdy←0, tx_busy←1, uart_tx←0 (start bit).
  - Parity is computed from the latched word: odd = ~^data, even = ^data.
- FSM states: IDLE → START → DATA (DATA_BITS bits, LSB first) → PARITY (only if enabled and PARITY≠0) → STOP (STOP_BITS bits) → IDLE.
- Bit timing: every bit, stop bits included, is held for exactly DIV cycles. A baud counter runs 0..DIV-1 and advances the FSM on terminal count. The counter is held at 0 in IDLE.
- Completion: on the edge ending the last stop bit, the FSM returns to IDLE.
  - At that edge: tx_rdy←1, tx_busy←0, tx_done←1. tx_done returns to 0 on the next edge.
- During a frame:
  - tx_vld is ignored; no second word is accepted.
  - Changes on tx_data are ignored.
  - Deasserting tx_vld has no effect.
- Reset mid-frame: uart_tx goes to 1 immediately (asynchronously). All outputs take their reset values. No tx_done pulse is produced. The partial frame is discarded.
- Illegal parameter values (DATA_BITS outside 5..9, STOP_BITS outside 1..2, DIV<2) are unsupported. The block must trigger an elaboration-time error for them.

## Timing

- Latency: uart_tx falls on the same edge that accepts the word.
- Frame length: FB = 1 + DATA_BITS + P + STOP_BITS, with P = 1 if parity is enabled, else 0.
- tx_done is high in the cycle starting FB×DIV cycles after the uart_tx falling edge.
- Back-to-back traffic with tx_vld held high: the next accept happens on the edge after tx_rdy rises. Consecutive start-bit falling edges are therefore FB×DIV + 1 cycles apart, with one extra idle-high cycle between frames.
- tx_done and a new accept may occur in the same cycle; both are legal.

## Configuration

- UART_TX_PARITY_EN defined: PARITY selects none/odd/even, and the parity bit is inserted after the data bits.
- UART_TX_PARITY_EN undefined: no parity logic is built, PARITY is ignored, and the frame is always 1 + DATA_BITS + STOP_BITS bits.

## Test plan

- 8N1, CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), send 0xA5.
  - uart_tx is 0,1,0,1,0,0,1,0,1,1, each for 10 cycles.
  - tx_done pulses for one cycle 100 cycles after the start edge; tx_rdy rises on that same edge.
- Back-to-back 0x00 then 0xFF with tx_vld held high.
  - Start edges are 101 cycles apart.
  - Two tx_done pulses; the second word is intact.
- Parity on (macro defined), DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x41.
  - Parity bit is 0, followed by two stop bits.
  - Frame is 11 bits = 110 cycles.
  - With PARITY=1, the same word gives parity bit 1.
- Reset asserted 35 cycles into a frame.
  - uart_tx=1 and tx_rdy=1 immediately; no tx_done pulse.
  - The next word 0x3C transmits correctly.
- During a frame, toggle tx_vld and change tx_data to 0xFF.
  - No accept occurs; the original word is transmitted unchanged; tx_rdy stays low until completion.
- Macro undefined with PARITY=2: the frame for 0x41 is 10 bits (8N1) with no parity bit.
